// File: rtl/al_clk_pkg.sv
// al_clk_pkg: shared definitions for the alarm-clock keypad time-entry path.
//   - command key codes (TIME / ALARM / CLEAR)
//   - entry FSM state encoding
//   - bcd_time_valid(): legality check of a packed BCD HH:MM value
package al_clk_pkg;

    localparam logic [3:0] KEY_TIME   = 4'hA;
    localparam logic [3:0] KEY_ALARM  = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;
    localparam logic [3:0] KEY_DIGMAX = 4'h9;
    localparam logic [2:0] MAX_DIGITS = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        LOAD_T = 2'd2,
        LOAD_A = 2'd3
    } entry_state_e;

    // A packed BCD value {ms_hour, ls_hour, ms_min, ls_min} is a legal
    // 24-hour time when hours are 00..23 and minutes 00..59.
    function automatic logic bcd_time_valid(input logic [15:0] t);
        logic [3:0] ms_hour;
        logic [3:0] ls_hour;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
        ms_hour = t[15:12];
        ls_hour = t[11:8];
        ms_min  = t[7:4];
        ls_min  = t[3:0];
        return (ms_hour <= 4'd2) && (ls_hour <= 4'd9) &&
               ((ms_hour != 4'd2) || (ls_hour <= 4'd3)) &&
               (ms_min <= 4'd5) && (ls_min <= 4'd9);
    endfunction

endpackage

// File: rtl/al_clk_entry_timer.sv
// al_clk_entry_timer: counts one-second ticks since the last accepted key.
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   i_clear   in   restart the count at zero (has priority over i_tick)
//   i_tick    in   one-second tick
//   o_expired out  registered, high while the count equals TIMEOUT_SECS
module al_clk_entry_timer #(
    parameter int unsigned TIMEOUT_SECS = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);

    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_SECS);

    logic [7:0] r_count;
    logic       r_expired;
    logic [7:0] w_count_nxt;

    // Next count: clear wins, and the count parks at the limit once reached.
    always_comb begin
        w_count_nxt = r_count;
        if (i_clear) begin
            w_count_nxt = 8'd0;
        end else if (i_tick && !r_expired) begin
            w_count_nxt = r_count + 8'd1;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Count register and registered expiry flag derived from the next count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= 8'd0;
            r_expired <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_expired <= (w_count_nxt == LP_LIMIT);
        end
    end

    assign o_expired = r_expired;

endmodule

// File: rtl/al_clk_time_entry.sv
// al_clk_time_entry: keypad HH:MM entry front end for the alarm clock.
// Collects BCD digit keys into a 4-digit buffer, validates it on TIME/ALARM
// command keys and drives the load interface of the counter / alarm register.
//   clk, reset_n          clock, asynchronous active-low reset
//   key_valid, key_code   1-cycle key strobe and code (0-9, A=TIME, B=ALARM, C=CLEAR)
//   one_second            1-cycle tick once per second
//   time_out              last loaded BCD time (changes only on a load)
//   load_new_time         1-cycle pulse: time_out valid for the clock counter
//   load_new_alarm        1-cycle pulse: time_out valid for the alarm register
//   entry_active          high while an entry is in progress
//   entry_buf             live digit buffer
//   entry_error           1-cycle pulse: command rejected as an invalid time
module al_clk_time_entry
    import al_clk_pkg::*;
#(
    parameter int unsigned TIMEOUT_SECS = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        one_second,
    output logic [15:0] time_out,
    output logic        load_new_time,
    output logic        load_new_alarm,
    output logic        entry_active,
    output logic [15:0] entry_buf,
    output logic        entry_error
);

    entry_state_e r_state;
    logic [15:0]  r_entry_buf;
    logic [2:0]   r_count;
    logic [15:0]  r_time_out;
    logic         r_load_time;
    logic         r_load_alarm;
    logic         r_entry_active;
    logic         r_entry_error;

    logic w_is_digit;
    logic w_is_clear;
    logic w_is_cmd;
    logic w_key_act;
    logic w_timer_clr;
    logic w_expired;

    assign w_is_digit = key_valid && (key_code <= KEY_DIGMAX);
    assign w_is_clear = key_valid && (key_code == KEY_CLEAR);
    assign w_is_cmd   = key_valid && ((key_code == KEY_TIME) || (key_code == KEY_ALARM));
    // D-F never count as activity, so they do not restart the timeout.
    assign w_key_act  = w_is_digit || w_is_clear || w_is_cmd;
    assign w_timer_clr = (r_state != ENTRY) || w_key_act || w_expired;

    al_clk_entry_timer #(
        .TIMEOUT_SECS (TIMEOUT_SECS)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_timer_clr),
        .i_tick    (one_second),
        .o_expired (w_expired)
    );

    // Entry FSM with digit buffer and registered load/error outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_entry_buf    <= 16'h0000;
            r_count        <= 3'd0;
            r_time_out     <= 16'h0000;
            r_load_time    <= 1'b0;
            r_load_alarm   <= 1'b0;
            r_entry_active <= 1'b0;
            r_entry_error  <= 1'b0;
        end else begin
            r_load_time   <= 1'b0;
            r_load_alarm  <= 1'b0;
            r_entry_error <= 1'b0;
            case (r_state)
                IDLE, ENTRY: begin
                    if (w_is_digit) begin
                        // Shifting left drops the oldest digit once four are held.
                        r_entry_buf    <= {r_entry_buf[11:0], key_code};
                        r_count        <= (r_count < MAX_DIGITS) ? r_count + 3'd1 : MAX_DIGITS;
                        r_state        <= ENTRY;
                        r_entry_active <= 1'b1;
                    end else if (w_is_clear) begin
                        r_entry_buf    <= 16'h0000;
                        r_count        <= 3'd0;
                        r_state        <= IDLE;
                        r_entry_active <= 1'b0;
                    end else if (w_is_cmd && (r_state == ENTRY)) begin
                        r_entry_active <= 1'b0;
                        if (bcd_time_valid(r_entry_buf)) begin
                            // Buffer is kept through the load cycle, cleared afterwards.
                            r_time_out   <= r_entry_buf;
                            r_load_time  <= (key_code == KEY_TIME);
                            r_load_alarm <= (key_code == KEY_ALARM);
                            r_state      <= (key_code == KEY_TIME) ? LOAD_T : LOAD_A;
                        end else begin
                            r_entry_error <= 1'b1;
                            r_entry_buf   <= 16'h0000;
                            r_count       <= 3'd0;
                            r_state       <= IDLE;
                        end
                    end else if ((r_state == ENTRY) && w_expired) begin
                        r_entry_buf    <= 16'h0000;
                        r_count        <= 3'd0;
                        r_state        <= IDLE;
                        r_entry_active <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                LOAD_T, LOAD_A: begin
                    // Any key arriving during the load cycle is dropped.
                    r_entry_buf    <= 16'h0000;
                    r_count        <= 3'd0;
                    r_state        <= IDLE;
                    r_entry_active <= 1'b0;
                end
                default: begin
                    r_entry_buf    <= 16'h0000;
                    r_count        <= 3'd0;
                    r_state        <= IDLE;
                    r_entry_active <= 1'b0;
                end
            endcase
        end
    end

    assign time_out       = r_time_out;
    assign load_new_time  = r_load_time;
    assign load_new_alarm = r_load_alarm;
    assign entry_active   = r_entry_active;
    assign entry_buf      = r_entry_buf;
    assign entry_error    = r_entry_error;

endmodule

// File: tb/tb_al_clk_time_entry.sv
`timescale 1ns/1ps
module tb_al_clk_time_entry;

    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        one_second = 1'b0;
    logic [15:0] time_out;
    logic        load_new_time;
    logic        load_new_alarm;
    logic        entry_active;
    logic [15:0] entry_buf;
    logic        entry_error;

    al_clk_time_entry #(.TIMEOUT_SECS(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .one_second     (one_second),
        .time_out       (time_out),
        .load_new_time  (load_new_time),
        .load_new_alarm (load_new_alarm),
        .entry_active   (entry_active),
        .entry_buf      (entry_buf),
        .entry_error    (entry_error)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: pulse kind (0 time, 1 alarm, 2 error), time_out value, edge number.
    typedef struct {
        int          kind;
        logic [15:0] val;
        int          cyc;
    } ev_t;

    ev_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_no = 0;

    // Reference model state: digits typed so far, entry flag, idle seconds.
    int          digits[$];
    bit          m_active  = 1'b0;
    bit          m_loading = 1'b0;
    int          m_secs    = 0;
    logic [15:0] m_time_out = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Entered digits as a BCD number, left-padded with zeros.
    function automatic logic [15:0] model_buf();
        int v = 0;
        foreach (digits[i]) v = v * 16 + digits[i];
        return v[15:0];
    endfunction

    function automatic bit model_valid(input logic [15:0] v);
        int hh;
        int mm;
        hh = 10 * int'(v[15:12]) + int'(v[11:8]);
        mm = 10 * int'(v[7:4])   + int'(v[3:0]);
        return (hh < 24) && (mm < 60);
    endfunction

    // Reference behaviour at one clock edge.
    task automatic model_edge(input bit kv, input int kc, input bit tick);
        ev_t e;
        logic [15:0] v;
        if (m_loading) begin
            m_loading = 1'b0;
            digits.delete();
        end else if (kv && kc <= 9) begin
            digits.push_back(kc);
            if (digits.size() > 4) void'(digits.pop_front());
            m_active = 1'b1;
            m_secs   = 0;
        end else if (kv && kc == 12) begin
            digits.delete();
            m_active = 1'b0;
            m_secs   = 0;
        end else if (kv && (kc == 10 || kc == 11) && m_active) begin
            v = model_buf();
            e.cyc = edge_no;
            if (model_valid(v)) begin
                e.kind     = (kc == 10) ? 0 : 1;
                m_time_out = v;
                m_loading  = 1'b1;
            end else begin
                e.kind = 2;
                digits.delete();
            end
            e.val = m_time_out;
            exp_q.push_back(e);
            m_active = 1'b0;
            m_secs   = 0;
        end else if (m_active && m_secs == TO) begin
            digits.delete();
            m_active = 1'b0;
            m_secs   = 0;
        end else if (m_active && tick) begin
            m_secs++;
        end
    endtask

    // One clock: drive inputs, update the model at the edge, check state 1ns later.
    task automatic step(input bit kv, input int kc, input bit tick);
        key_valid  = kv;
        key_code   = kc[3:0];
        one_second = tick;
        @(posedge clk);
        edge_no++;
        if (reset_n) model_edge(kv, kc, tick);
        #1;
        key_valid  = 1'b0;
        one_second = 1'b0;
        check("entry_buf", entry_buf, model_buf());
        check("entry_active", entry_active, m_active);
        check("time_out", time_out, m_time_out);
    endtask

    task automatic key(input int kc);
        step(1'b1, kc, 1'b0);
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        digits.delete();
        m_active   = 1'b0;
        m_loading  = 1'b0;
        m_secs     = 0;
        m_time_out = 16'h0000;
        #1;
        check("rst_entry_buf", entry_buf, 16'h0000);
        check("rst_time_out", time_out, 16'h0000);
        check("rst_flags", {load_new_time, load_new_alarm, entry_error, entry_active}, 4'b0000);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        reset_n = 1'b1;
    endtask

    // Monitor: compares the pulse outputs every cycle against the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (reset_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_no) begin
                e = exp_q.pop_front();
                check("pulse_kind", {load_new_time, load_new_alarm, entry_error},
                      (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001);
                check("pulse_time_out", time_out, e.val);
            end else begin
                check("no_pulse", {load_new_time, load_new_alarm, entry_error}, 3'b000);
            end
        end
    end

    initial begin
        int kv_r;
        int kc_r;
        int tk_r;
        step(1'b0, 0, 1'b0);
        check("init_time_out", time_out, 16'h0000);
        check("init_active", entry_active, 1'b0);
        reset_n = 1'b1;
        step(1'b0, 0, 1'b0);

        // Valid TIME load.
        key(1); key(2); key(3); key(4); key(10);
        check("t2_pulse", load_new_time, 1'b1);
        step(1'b0, 0, 1'b0);
        check("t2_time_out", time_out, 16'h1234);
        check("t2_active", entry_active, 1'b0);

        // Invalid time rejected.
        key(2); key(4); key(0); key(0); key(11);
        check("t3_error", entry_error, 1'b1);
        check("t3_buf", entry_buf, 16'h0000);
        step(1'b0, 0, 1'b0);
        check("t3_time_out", time_out, 16'h1234);

        // Three digits zero-extended, ALARM load; then A from IDLE is ignored.
        key(7); key(4); key(5); key(11);
        check("t4_alarm", load_new_alarm, 1'b1);
        check("t4_time_out", time_out, 16'h0745);
        step(1'b0, 0, 1'b0);
        key(10);
        step(1'b0, 0, 1'b0);

        // Timeout after TO ticks, no error.
        key(1); key(2);
        step(1'b0, 0, 1'b1); step(1'b0, 0, 1'b1); step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        check("t5_buf", entry_buf, 16'h0000);
        check("t5_active", entry_active, 1'b0);

        // Key and tick together restart the timer.
        key(1);
        step(1'b0, 0, 1'b1); step(1'b0, 0, 1'b1);
        step(1'b1, 2, 1'b1);
        step(1'b0, 0, 1'b1); step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        check("t5_restart_active", entry_active, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        check("t5_restart_expired", entry_active, 1'b0);

        // Five digits keep the last four; CLEAR; key during the load cycle dropped.
        key(1); key(2); key(3); key(4); key(5);
        check("t6_buf", entry_buf, 16'h2345);
        key(12);
        check("t6_clear", entry_buf, 16'h0000);
        key(1); key(2); key(3); key(4); key(10);
        key(9);
        step(1'b0, 0, 1'b0);
        check("t6_dropped_buf", entry_buf, 16'h0000);
        check("t6_dropped_active", entry_active, 1'b0);

        // Reset mid-entry and mid-pulse.
        key(1); key(5);
        do_reset();
        key(2); key(0); key(1); key(5); key(11);
        do_reset();
        check("t1_time_out", time_out, 16'h0000);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            kv_r = ($urandom_range(0, 99) < 40) ? 1 : 0;
            kc_r = ($urandom_range(0, 99) < 70) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            tk_r = ($urandom_range(0, 9) < 3) ? 1 : 0;
            step(kv_r[0], kc_r, tk_r[0]);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
